// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer for the byte-enabled data memory.
// Latency: gnt (combinational) in cycle N, memory access in N+1, rvalid in N+2.
// Backpressure: requesters hold req until gnt; one access per 2 cycles when back-to-back.
module dmem_arbiter #(
   parameter int MEM_WORDS  = 512,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   input  logic [1:0]  size0,
   input  logic [1:0]  size1,
   input  logic        sgn0,
   input  logic        sgn1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata,
   output logic        rerr,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic [3:0]  mem_byteen,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        owner;
   logic        last_grant;
   logic        reg_we;
   logic        reg_err;
   logic [31:0] reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_byteen;

   logic        arb_phase;
   logic        any_req;
   logic        sel1;
   logic        sel_we;
   logic        sel_sgn;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [1:0]  sel_size;
   logic        sel_err;
   logic [3:0]  sel_byteen;

   // Arbitration is only possible when no access is being performed.
   assign arb_phase = (state == IDLE) || (state == RESP);
   assign any_req   = req0 | req1;

   // Winner selection: lone requester wins; on contention fixed priority or alternate.
   always_comb begin
      sel1 = 1'b0;
      if (req1 && !req0) begin
         sel1 = 1'b1;
      end else if (req1 && req0 && !FIXED_PRIO && (last_grant == 1'b0)) begin
         sel1 = 1'b1;
      end
   end

   // Winning request fields, error check and ByteEn encoding (captured at grant).
   always_comb begin
      sel_we    = sel1 ? we1    : we0;
      sel_sgn   = sel1 ? sgn1   : sgn0;
      sel_addr  = sel1 ? addr1  : addr0;
      sel_wdata = sel1 ? wdata1 : wdata0;
      sel_size  = sel1 ? size1  : size0;
      sel_err   = (sel_size == 2'b11)
                | ((sel_size == 2'b01) && sel_addr[0])
                | ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00))
                | ({2'b00, sel_addr[31:2]} >= 32'(MEM_WORDS));
      sel_byteen = 4'b0000;
      if (!sel_err) begin
         case (sel_size)
            2'b00:   sel_byteen = (sel_sgn && !sel_we) ? 4'b1001 : 4'b0001;
            2'b01:   sel_byteen = (sel_sgn && !sel_we) ? 4'b1011 : 4'b0011;
            2'b10:   sel_byteen = 4'b1111;
            default: sel_byteen = 4'b0000;
         endcase
      end
   end

   // State register; reset aborts any in-flight access immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: every grant leads to one ACCESS then one RESP cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = any_req ? ACCESS : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: grant pulse, single-cycle write strobe and response valid.
   always_comb begin
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      mem_we  = 1'b0;
      rvalid0 = 1'b0;
      rvalid1 = 1'b0;
      if (arb_phase && any_req && !reset) begin
         gnt0 = !sel1;
         gnt1 = sel1;
      end
      if (state == ACCESS) begin
         mem_we = reg_we & ~reg_err;
      end
      if (state == RESP) begin
         rvalid0 = !owner;
         rvalid1 = owner;
      end
   end

   // Capture the granted request; memory-side outputs hold between accesses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner      <= 1'b0;
         last_grant <= 1'b1;
         reg_we     <= 1'b0;
         reg_err    <= 1'b0;
         reg_addr   <= 32'h0;
         reg_wdata  <= 32'h0;
         reg_byteen <= 4'b0000;
      end else if (arb_phase && any_req) begin
         owner      <= sel1;
         last_grant <= sel1;
         reg_we     <= sel_we;
         reg_err    <= sel_err;
         reg_addr   <= sel_addr;
         reg_wdata  <= sel_wdata;
         reg_byteen <= sel_byteen;
      end
   end

   // Latch the response at the end of ACCESS; it holds until the next access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata <= 32'h0;
         rerr  <= 1'b0;
      end else if (state == ACCESS) begin
         rdata <= (reg_we | reg_err) ? 32'h0 : mem_rd;
         rerr  <= reg_err;
      end
   end

   assign mem_a      = reg_addr;
   assign mem_wd     = reg_wdata;
   assign mem_byteen = reg_byteen;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, random traffic against a spec-level model,
// contention ordering for both arbitration modes, and reset abort of a store.
// Stimulus is driven 1 time unit after posedge; outputs are sampled at negedge.
module tb_dmem_arbiter;

   localparam int MW = 512;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1, sgn0, sgn1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic [1:0]  size0, size1;
   logic        gnt0, gnt1, rvalid0, rvalid1, rerr, mem_we;
   logic [31:0] rdata, mem_a, mem_wd, mem_rd;
   logic [3:0]  mem_byteen;

   logic        fgnt0, fgnt1, frvalid0, frvalid1, frerr, fmem_we;
   logic [31:0] frdata, fmem_a, fmem_wd;
   logic [3:0]  fmem_byteen;

   int tests;
   int fails;

   always #5 clk = ~clk;

   dmem_arbiter #(.MEM_WORDS(MW), .FIXED_PRIO(1'b0)) u_dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .size0(size0), .size1(size1), .sgn0(sgn0), .sgn1(sgn1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .rerr(rerr), .mem_we(mem_we), .mem_a(mem_a),
      .mem_wd(mem_wd), .mem_byteen(mem_byteen), .mem_rd(mem_rd)
   );

   dmem_arbiter #(.MEM_WORDS(MW), .FIXED_PRIO(1'b1)) u_fix (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .size0(size0), .size1(size1), .sgn0(sgn0), .sgn1(sgn1),
      .gnt0(fgnt0), .gnt1(fgnt1), .rvalid0(frvalid0), .rvalid1(frvalid1),
      .rdata(frdata), .rerr(frerr), .mem_we(fmem_we), .mem_a(fmem_a),
      .mem_wd(fmem_wd), .mem_byteen(fmem_byteen), .mem_rd(32'h0)
   );

   // ---------------- data memory environment (combinational read, clocked write)
   logic [31:0] dmem [MW] = '{default: 32'h0};
   logic [31:0] env_w;
   logic [7:0]  env_b;
   logic [15:0] env_h;
   logic        env_in;

   assign env_in = (mem_a[31:11] == 21'h0);

   always_comb begin
      env_w  = 32'h0;
      env_b  = 8'h0;
      env_h  = 16'h0;
      mem_rd = 32'h0;
      if (env_in) env_w = dmem[mem_a[10:2]];
      env_b = env_w[{mem_a[1:0], 3'b000} +: 8];
      env_h = mem_a[1] ? env_w[31:16] : env_w[15:0];
      case (mem_byteen[2:0])
         3'b001:  mem_rd = mem_byteen[3] ? {{24{env_b[7]}}, env_b} : {24'h0, env_b};
         3'b011:  mem_rd = mem_byteen[3] ? {{16{env_h[15]}}, env_h} : {16'h0, env_h};
         3'b111:  mem_rd = env_w;
         default: mem_rd = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      if (mem_we && env_in) begin
         case (mem_byteen[2:0])
            3'b001:  dmem[mem_a[10:2]][{mem_a[1:0], 3'b000} +: 8] <= mem_wd[7:0];
            3'b011:  dmem[mem_a[10:2]][{mem_a[1], 4'b0000} +: 16] <= mem_wd[15:0];
            3'b111:  dmem[mem_a[10:2]] <= mem_wd;
            default: ;
         endcase
      end
   end

   // ---------------- reference model: byte-addressed memory image
   logic [31:0] ref_mem [MW];

   task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sg,
                        output logic e, output logic [31:0] rd);
      int idx, off, nb;
      logic [31:0] w, v, mask;
      idx = int'(a >> 2);
      off = int'(a[1:0]);
      nb  = 1 << sz;
      e   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 0) || (idx >= MW);
      rd  = 32'h0;
      if (!e) begin
         w = ref_mem[idx];
         if (we) begin
            for (int k = 0; k < nb; k++) w[8*(off+k) +: 8] = wd[8*k +: 8];
            ref_mem[idx] = w;
         end else begin
            mask = (nb == 1) ? 32'hFF : (nb == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
            v = (w >> (8 * off)) & mask;
            if (sg && nb < 4 && v[8*nb-1]) v = v | ~mask;
            rd = v;
         end
      end
   endtask

   function automatic logic [3:0] exp_byteen(input logic e, input logic we,
                                             input logic [1:0] sz, input logic sg);
      if (e) return 4'b0000;
      if (sz == 2'd2) return 4'b1111;
      return ((sz == 2'd1) ? 4'b0011 : 4'b0001) | ((sg && !we) ? 4'b1000 : 4'b0000);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One complete access on port p, checked through grant, ACCESS and RESP.
   // Called 1 unit after a posedge with the DUT idle; returns the same way.
   task automatic do_access(input logic p, input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                            input logic e, input logic [3:0] be, input logic [31:0] rd);
      int  waited;
      bit  got;
      if (!p) begin
         req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; size0 = sz; sgn0 = sg;
      end else begin
         req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; size1 = sz; sgn1 = sg;
      end
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 20) begin
         @(negedge clk);
         if (p ? gnt1 : gnt0) got = 1'b1;
         else begin
            @(posedge clk); #1;
            waited++;
         end
      end
      if (!got) begin
         check("gnt_timeout", 32'(waited), 32'd0);
         req0 = 1'b0; req1 = 1'b0;
         return;
      end
      check("gnt_exclusive", 32'(p ? gnt0 : gnt1), 32'd0);
      check("gnt_latency", 32'(waited), 32'd0);
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      check("access_mem_we", 32'(mem_we), 32'(we && !e));
      check("access_byteen", 32'(mem_byteen), 32'(be));
      check("access_addr", mem_a, a);
      check("access_no_gnt", 32'({gnt1, gnt0}), 32'd0);
      check("access_no_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("resp_rvalid", 32'({rvalid1, rvalid0}), p ? 32'd2 : 32'd1);
      check("resp_rdata", rdata, rd);
      check("resp_rerr", 32'(rerr), 32'(e));
      check("resp_mem_we_low", 32'(mem_we), 32'd0);
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic        p;
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      logic [1:0]  sz;
      logic        sg;
      logic        e;
      logic [3:0]  be;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs [16];

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic        me, p, we, sg;
      logic [31:0] mrd, a, wd;
      logic [1:0]  sz;
      int          r, bad;
      logic [1:0]  exp_a, exp_f;

      tests = 0;
      fails = 0;
      for (int i = 0; i < MW; i++) ref_mem[i] = 32'h0;
      reset = 1'b1;
      req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; sgn0 = 1'b0; sgn1 = 1'b0;
      addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
      size0 = 2'd2; size1 = 2'd2;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ctrl", 32'({gnt0, gnt1, rvalid0, rvalid1, rerr, mem_we}), 32'd0);
      check("reset_data", rdata | mem_a | mem_wd | 32'(mem_byteen), 32'd0);
      check("reset_fix", 32'({fgnt0, fgnt1, frvalid0, frvalid1, frerr, fmem_we}) |
            frdata | fmem_a | fmem_wd | 32'(fmem_byteen), 32'd0);
      req0 = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;

      // Directed table
      vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 4'b1111, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 1'b0, 4'b1111, 32'hDEADBEEF};
      vecs[2]  = '{1'b1, 1'b1, 32'h13,  32'h80,       2'd0, 1'b1, 1'b0, 4'b0001, 32'h0};
      vecs[3]  = '{1'b1, 1'b0, 32'h13,  32'h0,        2'd0, 1'b1, 1'b0, 4'b1001, 32'hFFFFFF80};
      vecs[4]  = '{1'b1, 1'b0, 32'h13,  32'h0,        2'd0, 1'b0, 1'b0, 4'b0001, 32'h00000080};
      vecs[5]  = '{1'b1, 1'b1, 32'h22,  32'hABCD,     2'd1, 1'b0, 1'b0, 4'b0011, 32'h0};
      vecs[6]  = '{1'b1, 1'b0, 32'h22,  32'h0,        2'd1, 1'b0, 1'b0, 4'b0011, 32'h0000ABCD};
      vecs[7]  = '{1'b0, 1'b0, 32'h22,  32'h0,        2'd1, 1'b1, 1'b0, 4'b1011, 32'hFFFFABCD};
      vecs[8]  = '{1'b0, 1'b0, 32'h12,  32'h0,        2'd2, 1'b0, 1'b1, 4'b0000, 32'h0};
      vecs[9]  = '{1'b1, 1'b1, 32'h21,  32'h1234,     2'd1, 1'b0, 1'b1, 4'b0000, 32'h0};
      vecs[10] = '{1'b0, 1'b0, 32'h20,  32'h0,        2'd3, 1'b0, 1'b1, 4'b0000, 32'h0};
      vecs[11] = '{1'b1, 1'b1, 32'h800, 32'h55555555, 2'd2, 1'b0, 1'b1, 4'b0000, 32'h0};
      vecs[12] = '{1'b0, 1'b0, 32'h20,  32'h0,        2'd2, 1'b0, 1'b0, 4'b1111, 32'hABCD0000};
      vecs[13] = '{1'b0, 1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 1'b0, 4'b1111, 32'h80ADBEEF};
      vecs[14] = '{1'b1, 1'b1, 32'h23,  32'hFFFFFF7E, 2'd0, 1'b0, 1'b0, 4'b0001, 32'h0};
      vecs[15] = '{1'b0, 1'b0, 32'h20,  32'h0,        2'd2, 1'b0, 1'b0, 4'b1111, 32'h7ECD0000};
      for (int i = 0; i < 16; i++) begin
         model(vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].sz, vecs[i].sg, me, mrd);
         do_access(vecs[i].p, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].sz, vecs[i].sg,
                   vecs[i].e, vecs[i].be, vecs[i].rd);
      end

      // Random traffic against the reference model
      for (int n = 0; n < 300; n++) begin
         p  = 1'($urandom_range(0, 1));
         we = 1'($urandom_range(0, 1));
         sg = 1'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 9));
         sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         a  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) a = (sz == 2'd1) ? (a & ~32'h1) : (sz == 2'd2) ? (a & ~32'h3) : a;
         if ($urandom_range(0, 19) == 0) a = $urandom | 32'h800;
         wd = $urandom;
         model(we, a, wd, sz, sg, me, mrd);
         do_access(p, we, a, wd, sz, sg, me, exp_byteen(me, we, sz, sg), mrd);
      end

      // Reset in the middle of a store's ACCESS cycle
      model(1'b1, 32'h40, 32'h11111111, 2'd2, 1'b0, me, mrd);
      do_access(1'b0, 1'b1, 32'h40, 32'h11111111, 2'd2, 1'b0, me, 4'b1111, mrd);
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h22222222; size0 = 2'd2; sgn0 = 1'b0;
      @(negedge clk);
      check("abort_gnt", 32'(gnt0), 32'd1);
      @(posedge clk); #1;
      req0 = 1'b0;
      check("abort_we_high", 32'(mem_we), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("abort_we_drop", 32'(mem_we), 32'd0);
      check("abort_byteen_zero", 32'(mem_byteen), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("abort_no_rvalid", 32'({rvalid1, rvalid0, frvalid1, frvalid0}), 32'd0);
      end
      @(posedge clk); #1;
      reset = 1'b0;

      // Continuous contention: round-robin alternates, fixed priority always port 0
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0; size0 = 2'd2; sgn0 = 1'b0;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4; size1 = 2'd2; sgn1 = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         exp_a = (c % 2 == 1) ? 2'b00 : ((c % 4 == 0) ? 2'b01 : 2'b10);
         exp_f = (c % 2 == 1) ? 2'b00 : 2'b01;
         check("rr_grant", 32'({gnt1, gnt0}), 32'(exp_a));
         check("fixed_grant", 32'({fgnt1, fgnt0}), 32'(exp_f));
         @(posedge clk); #1;
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end

      // The aborted store must not have reached memory
      model(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, me, mrd);
      do_access(1'b1, 1'b0, 32'h40, 32'h0, 2'd2, 1'b0, me, 4'b1111, 32'h11111111);

      // Whole memory image must match the model (errored stores changed nothing)
      bad = 0;
      for (int i = 0; i < MW; i++) if (dmem[i] !== ref_mem[i]) bad++;
      check("memory_image_mismatches", 32'(bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
